// File: rtl/regfile_fwd_pkg.sv
// Shared constants for the ID-stage register file and operand forwarding network.
package regfile_fwd_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam logic                  RST_ENABLE   = 1'b1;
  localparam logic                  WRITE_ENABLE = 1'b1;
  localparam logic                  READ_ENABLE  = 1'b1;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

  // Operand source chosen by a read port, youngest producer first.
  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_MEM,
    SRC_WB,
    SRC_ARRAY
  } src_e;

endpackage

// File: rtl/regfile_fwd_mux.sv
// One read port: picks the operand from EX, MEM, WB or the array, and flags a load-use hit.
module fwd_mux
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] rdata,
  output logic              load_use
);

  src_e src;
  logic rd_active;
  logic ex_hit;

  assign rd_active = (re == READ_ENABLE) && (raddr != ADDR_W'(NOP_REG_ADDR));
  assign ex_hit    = ex_we && (ex_waddr == raddr);

  always_comb begin
    src = SRC_ARRAY;
    if (!rd_active)                          src = SRC_ZERO;
    else if (ex_hit)                         src = ex_is_load ? SRC_ZERO : SRC_EX;
    else if (mem_we && mem_waddr == raddr)   src = SRC_MEM;
    else if (wb_we && wb_waddr == raddr)     src = SRC_WB;
  end

  always_comb begin
    rdata = '0;
    case (src)
      SRC_EX:    rdata = ex_wdata;
      SRC_MEM:   rdata = mem_wdata;
      SRC_WB:    rdata = wb_wdata;
      SRC_ARRAY: rdata = arr_data;
      default:   rdata = '0;
    endcase
  end

  // A load in EX has no data yet; the consumer must wait until it reaches MEM.
  assign load_use = rd_active && ex_hit && ex_is_load;

endmodule

// File: rtl/regfile_fwd.sv
// 32x32 GPR file with WB write port and two forwarded ID-stage read ports.
module regfile_fwd
  import regfile_fwd_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_is_load,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              stall_req
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] mux_rdata1, mux_rdata2;
  logic              load_use1, load_use2;
  logic              in_rst;

  assign in_rst = (rst == RST_ENABLE);

  always_comb begin
    regs_d = regs_q;
    if (we == WRITE_ENABLE && waddr != ADDR_W'(NOP_REG_ADDR))
      regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (in_rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port1 (
    .re(re1), .raddr(raddr1),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(we), .wb_waddr(waddr), .wb_wdata(wdata),
    .arr_data(regs_q[raddr1]), .rdata(mux_rdata1), .load_use(load_use1)
  );

  fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port2 (
    .re(re2), .raddr(raddr2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_we(we), .wb_waddr(waddr), .wb_wdata(wdata),
    .arr_data(regs_q[raddr2]), .rdata(mux_rdata2), .load_use(load_use2)
  );

  // Reset masks the read ports combinationally so ID sees zeros immediately.
  assign rdata1    = in_rst ? '0 : mux_rdata1;
  assign rdata2    = in_rst ? '0 : mux_rdata2;
  assign stall_req = !in_rst && (load_use1 || load_use2);

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: reference model checked every cycle plus literal spot checks.
module tb_regfile_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic        we, ex_we, ex_is_load, mem_we, re1, re2;
  logic [4:0]  waddr, ex_waddr, mem_waddr, raddr1, raddr2;
  logic [31:0] wdata, ex_wdata, mem_wdata;
  logic [31:0] rdata1, rdata2;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  logic [31:0] m_regs [32];

  regfile_fwd dut (
    .clk(clk), .rst(rst),
    .we(we), .waddr(waddr), .wdata(wdata),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Reference state: what the architectural register file holds.
  initial for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
    end else if (we && waddr != 5'd0) begin
      m_regs[waddr] <= wdata;
    end
  end

  // Operand value: scan producers youngest-first, fall back to the architectural value.
  function automatic logic [31:0] model_read(input logic en, input logic [4:0] a);
    logic        pv [3];
    logic [4:0]  pa [3];
    logic [31:0] pd [3];
    if (rst || !en || a == 5'd0) return 32'h0;
    pv[0] = ex_we;  pa[0] = ex_waddr;  pd[0] = ex_is_load ? 32'h0 : ex_wdata;
    pv[1] = mem_we; pa[1] = mem_waddr; pd[1] = mem_wdata;
    pv[2] = we;     pa[2] = waddr;     pd[2] = wdata;
    for (int k = 0; k < 3; k++)
      if (pv[k] && pa[k] == a) return pd[k];
    return m_regs[a];
  endfunction

  function automatic logic model_stall();
    if (rst || !ex_we || !ex_is_load || ex_waddr == 5'd0) return 1'b0;
    return (re1 && raddr1 == ex_waddr) || (re2 && raddr2 == ex_waddr);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      check("cmp_rdata1", rdata1, model_read(re1, raddr1));
      check("cmp_rdata2", rdata2, model_read(re2, raddr2));
      check("cmp_stall", {31'h0, stall_req}, {31'h0, model_stall()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_buses();
    we = 0; waddr = 0; wdata = 0;
    ex_we = 0; ex_waddr = 0; ex_wdata = 0; ex_is_load = 0;
    mem_we = 0; mem_waddr = 0; mem_wdata = 0;
  endtask

  initial begin
    rst = 1; clear_buses();
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
    tick(); tick();

    // Reset overrides reads and a pending load-use.
    re1 = 1; raddr1 = 5; ex_we = 1; ex_is_load = 1; ex_waddr = 5; #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_stall", {31'h0, stall_req}, 32'h0);
    tick();

    // Write r5, then reset clears it; write during reset is dropped.
    rst = 0; clear_buses(); we = 1; waddr = 5; wdata = 32'h1234; tick();
    we = 0; #1; check("r5_written", rdata1, 32'h1234);
    rst = 1; we = 1; waddr = 6; wdata = 32'hDEAD; tick();
    rst = 0; we = 0; #1; check("r5_after_rst", rdata1, 32'h0);
    raddr1 = 6; #1; check("r6_rst_write_dropped", rdata1, 32'h0);

    // r0 stays zero against WB writes and bus matches.
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr1 = 0; #1;
    check("r0_wb_bypass", rdata1, 32'h0);
    tick(); we = 0; #1; check("r0_array", rdata1, 32'h0);
    ex_we = 1; ex_waddr = 0; ex_wdata = 32'hBEEF; ex_is_load = 1; #1;
    check("r0_ex_match", rdata1, 32'h0);
    check("r0_no_stall", {31'h0, stall_req}, 32'h0);
    tick(); clear_buses();

    // Write-through bypass, then array.
    we = 1; waddr = 3; wdata = 32'hA5A5A5A5; raddr1 = 3; #1;
    check("wb_bypass", rdata1, 32'hA5A5A5A5);
    tick(); we = 0; #1; check("wb_array", rdata1, 32'hA5A5A5A5);

    // Producer priority on r7, both ports reading it.
    we = 1; waddr = 7; wdata = 32'h1; tick();
    wdata = 32'h2; mem_we = 1; mem_waddr = 7; mem_wdata = 32'h3;
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'h4;
    raddr1 = 7; re2 = 1; raddr2 = 7; #1;
    check("prio_ex", rdata1, 32'h4);
    check("prio_ex_p2", rdata2, 32'h4);
    ex_we = 0; #1; check("prio_mem", rdata1, 32'h3);
    mem_we = 0; #1; check("prio_wb", rdata1, 32'h2);
    tick(); we = 0; #1; check("prio_array", rdata2, 32'h2);

    // Load-use on port 2.
    ex_we = 1; ex_is_load = 1; ex_waddr = 9; ex_wdata = 32'h999; raddr2 = 9; re2 = 1; #1;
    check("lu_stall", {31'h0, stall_req}, 32'h1);
    check("lu_rdata2", rdata2, 32'h0);
    re2 = 0; #1; check("lu_re2_off", {31'h0, stall_req}, 32'h0);
    re2 = 1; tick();
    clear_buses(); mem_we = 1; mem_waddr = 9; mem_wdata = 32'h55; #1;
    check("lu_mem_fwd", rdata2, 32'h55);
    check("lu_released", {31'h0, stall_req}, 32'h0);
    tick(); clear_buses();

    // Disabled read port.
    we = 1; waddr = 4; wdata = 32'h77; tick(); we = 0;
    re1 = 0; raddr1 = 4; #1; check("re1_off", rdata1, 32'h0);
    re1 = 1; #1; check("re1_on", rdata1, 32'h77);

    // A few mixed cycles for the model comparison.
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); waddr = 5'($urandom_range(0, 7)); wdata = $urandom;
      mem_we = 1'($urandom); mem_waddr = 5'($urandom_range(0, 7)); mem_wdata = $urandom;
      ex_we = 1'($urandom); ex_waddr = 5'($urandom_range(0, 7)); ex_wdata = $urandom;
      ex_is_load = 1'($urandom);
      re1 = 1'($urandom); raddr1 = 5'($urandom_range(0, 7));
      re2 = 1'($urandom); raddr2 = 5'($urandom_range(0, 7));
      tick();
    end

    @(negedge clk); #1;
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
